sync_fifo_prog: RTL

SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

---
 rtl/sync_fifo_prog.sv | 93 +++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with a registered read port and programmable almost-full/almost-empty levels.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_PROG_ERR_FLAGS_EN is defined.
module sync_fifo_prog #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_en,
    input  logic                    r_en,
    input  logic [DATA_WIDTH-1:0]   data_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic                    almost_empty,
    output logic [$clog2(DEPTH):0]  count
`ifdef SYNC_FIFO_PROG_ERR_FLAGS_EN
    ,
    output logic                    overflow,
    output logic                    underflow
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  wr_accept;
    logic                  rd_accept;

    // Handshake: a read is taken whenever r_en=1 and the FIFO holds data; a write is
    // taken whenever w_en=1 and there is room, where a same-cycle read counts as room.
    // Requests that are not taken have no effect on data, pointers or count.
    assign rd_accept = r_en && !empty;
    assign wr_accept = w_en && (!full || rd_accept);

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Storage is never reset; the pointers and count alone define which entries are live.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            data_out <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr   <= rd_ptr + AW'(1);
                data_out <= mem[rd_ptr];
            end
            case ({wr_accept, rd_accept})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef SYNC_FIFO_PROG_ERR_FLAGS_EN
    // A read against an empty FIFO paired with a write is not an error: the write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (w_en && !wr_accept) begin
                overflow <= 1'b1;
            end
            if (r_en && empty && !w_en) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule
